// File: rtl/sharpen_frame_sequencer.sv
// sharpen_frame_sequencer
// Streams a raster-order IMG_W x IMG_H frame through an external combinational
// 3x3 sharpen kernel. Holds two line buffers, two window column registers and
// the frame FSM, and registers the kernel result behind a valid/ready output.
// Only interior pixels are produced: (IMG_W-2) x (IMG_H-2) results per frame.
// Optional feature macro: SHARPEN_SAT_STATS_EN enables the sat_count statistic
// (results equal to 0 or full scale); when undefined sat_count is tied to 0.
module sharpen_frame_sequencer #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8,
  parameter int KW    = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [KW-1:0]    win_p0,
  output logic [KW-1:0]    win_p1,
  output logic [KW-1:0]    win_p2,
  output logic [KW-1:0]    win_p3,
  output logic [KW-1:0]    win_p4,
  output logic [KW-1:0]    win_p5,
  output logic [KW-1:0]    win_p6,
  output logic [KW-1:0]    win_p7,
  output logic [KW-1:0]    win_p8,
  input  logic [KW-1:0]    kern_result,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      sat_count
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
  localparam logic [PIX_W-1:0] PIX_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          state;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;

  // lb0 holds the previous row, lb1 the row before that
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];

  // Column registers: c1_* is column c-1, c2_* is column c-2 (top/mid/bottom)
  logic [PIX_W-1:0] c1_top, c1_mid, c1_bot;
  logic [PIX_W-1:0] c2_top, c2_mid, c2_bot;

  logic accept;
  logic win_valid;
  logic unused_kern_hi;

  assign in_ready  = ((state == S_FILL) || (state == S_RUN)) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign win_valid = (row >= RW'(2)) && (col >= CW'(2));

  // Only the low PIX_W bits of the clipped kernel result are meaningful
  assign unused_kern_hi = ^kern_result[KW-1:PIX_W];

  // Window presented to the kernel, zero-extended; the newest column is live
  assign win_p0 = KW'(c2_top);
  assign win_p3 = KW'(c2_mid);
  assign win_p6 = KW'(c2_bot);
  assign win_p1 = KW'(c1_top);
  assign win_p4 = KW'(c1_mid);
  assign win_p7 = KW'(c1_bot);
  assign win_p2 = KW'(lb1[col]);
  assign win_p5 = KW'(lb0[col]);
  assign win_p8 = KW'(in_data);

  // Frame FSM with raster position counters and registered busy/frame_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      row        <= '0;
      col        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so the later case statement may override row/col.
      frame_done <= 1'b0;
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FILL;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
          end
        end
        S_FILL: begin
          if (accept && (row == RW'(1)) && (col == COL_LAST)) state <= S_RUN;
        end
        S_RUN: begin
          if (accept && (row == ROW_LAST) && (col == COL_LAST)) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (!out_valid) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line buffers and window column shift on every accepted pixel
  // NOTE: storage is deliberately not reset; a frame always rewrites a
  // location before any valid window reads it, and no reset keeps it RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= in_data;
      c2_top   <= c1_top;
      c2_mid   <= c1_mid;
      c2_bot   <= c1_bot;
      c1_top   <= lb1[col];
      c1_mid   <= lb0[col];
      c1_bot   <= in_data;
    end
  end

  // Output register: load on a valid window, drain on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (accept && win_valid) begin
      out_data  <= kern_result[PIX_W-1:0];
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SHARPEN_SAT_STATS_EN
  // Count delivered results at either clip rail, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if ((state == S_IDLE) && start) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && ((out_data == '0) || (out_data == PIX_MAX))
                 && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_sharpen_frame_sequencer.sv
// Self-checking bench for sharpen_frame_sequencer. Provides the external
// combinational sharpen kernel, drives whole frames (constant, impulse, ramp,
// zero, random) with optional input gaps and random output backpressure, and
// compares every delivered pixel against a frame-level reference model.
`timescale 1ns/1ps
module tb_sharpen_frame_sequencer;

  localparam int W    = 64;
  localparam int H    = 64;
  localparam int PW   = 8;
  localparam int KW   = 13;
  localparam int NPIX = W * H;
  localparam int NOUT = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [KW-1:0] win_p0, win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7, win_p8;
  logic [KW-1:0] kern_result;
  logic [PW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          frame_done;
  logic [15:0]   sat_count;

  int checks   = 0;
  int failures = 0;
  int img     [NPIX];
  int out_img [NPIX];
  int exp_q[$];
  int pos_q[$];
  int fd_count  = 0;
  int out_count = 0;
  bit bp_en     = 1'b0;
  int ks;
  int mon_e, mon_p;

  always #5 clk = ~clk;

  sharpen_frame_sequencer #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .win_p0(win_p0), .win_p1(win_p1), .win_p2(win_p2),
    .win_p3(win_p3), .win_p4(win_p4), .win_p5(win_p5),
    .win_p6(win_p6), .win_p7(win_p7), .win_p8(win_p8),
    .kern_result(kern_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done), .sat_count(sat_count)
  );

  // External sharpen kernel: 5*centre minus the four neighbours, clipped 0..255
  always_comb begin
    ks = 5 * int'(win_p4) - int'(win_p1) - int'(win_p3) - int'(win_p5) - int'(win_p7);
    if (ks < 0) ks = 0;
    else if (ks > 255) ks = 255;
    kern_result = KW'(ks);
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int pix_val(input int mode, input int r, input int c);
    case (mode)
      0:       return 100;
      1:       return (r == 10 && c == 10) ? 50 : 0;
      2:       return (r + c) & 255;
      3:       return 0;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic int model_px(input int r, input int c);
    int v;
    v = 5 * img[r*W+c] - img[(r-1)*W+c] - img[(r+1)*W+c] - img[r*W+c-1] - img[r*W+c+1];
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  // Random or always-on downstream readiness, changed just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: every delivered pixel, backpressure rule, frame_done timing
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_p = pos_q.pop_front();
          check("out_data", int'(out_data), mon_e);
          out_img[mon_p] = int'(out_data);
          out_count++;
        end
      end
      if (out_valid && !out_ready) check("in_ready_under_bp", int'(in_ready), 0);
      if (frame_done) begin
        fd_count++;
        check("done_after_last", exp_q.size(), 0);
        check("done_busy_low", int'(busy), 0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_sat_count"}, int'(sat_count), 0);
  endtask

  // One frame: build image and expectations, start, stream, then finish or abort
  task automatic run_frame(input int mode, input bit bp, input bit gaps,
                           input int abort_at, input bit poke_start);
    int k, cyc, t, sat_exp, fd0, v;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r*W+c] = pix_val(mode, r, c);
    exp_q.delete();
    pos_q.delete();
    sat_exp = 0;
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) begin
        v = model_px(r, c);
        exp_q.push_back(v);
        pos_q.push_back(r * W + c);
        if (v == 0 || v == 255) sat_exp++;
      end
`ifndef SHARPEN_SAT_STATS_EN
    sat_exp = 0;
`endif
    for (int i = 0; i < NPIX; i++) out_img[i] = -1;
    bp_en     = bp;
    fd0       = fd_count;
    out_count = 0;

    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 0);
    check("idle_busy", int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("sat_cleared_on_start", int'(sat_count), 0);

    k   = 0;
    cyc = 0;
    in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    in_data  = PW'(img[0]);
    while (k < NPIX && cyc < 40000) begin
      @(negedge clk);
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
      cyc++;
      start = poke_start && (k == 2000);
      if (k == abort_at) break;
      in_valid = (k < NPIX) && (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data  = (k < NPIX) ? PW'(img[k]) : '0;
    end
    start    = 1'b0;
    in_valid = 1'b0;

    if (abort_at >= 0) begin
      check("abort_input_count", k, abort_at);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      exp_q.delete();
      pos_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("abort_no_frame_done", fd_count - fd0, 0);
      check("abort_idle_busy", int'(busy), 0);
      return;
    end

    check("input_count", k, NPIX);
    if (!bp && !gaps) check("throughput_cycles", cyc, NPIX);
    t = 0;
    while (fd_count == fd0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("frame_done_seen", fd_count - fd0, 1);
    check("sat_count_frame", int'(sat_count), sat_exp);
    repeat (5) @(negedge clk);
    check("frame_done_once", fd_count - fd0, 1);
    check("output_count", out_count, NOUT);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    // Reset, then a second reset asserted mid-idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_start_in_ready", int'(in_ready), 0);

    // Constant frame at full rate
    run_frame(0, 1'b0, 1'b0, -1, 1'b0);
    check("const_1_1", out_img[1*W+1], 100);
    check("const_62_62", out_img[62*W+62], 100);
    check("const_1_62", out_img[1*W+62], 100);

    // Impulse at (10,10)
    run_frame(1, 1'b0, 1'b0, -1, 1'b0);
    check("impulse_centre", out_img[10*W+10], 250);
    check("impulse_up", out_img[9*W+10], 0);
    check("impulse_down", out_img[11*W+10], 0);
    check("impulse_left", out_img[10*W+9], 0);
    check("impulse_right", out_img[10*W+11], 0);
    check("impulse_far", out_img[30*W+30], 0);

    // Ramp frame under random backpressure
    run_frame(2, 1'b1, 1'b0, -1, 1'b0);
    check("ramp_5_7", out_img[5*W+7], 12);
    check("ramp_62_62", out_img[62*W+62], 124);

    // Abort after 1000 inputs, then a clean constant frame
    run_frame(0, 1'b0, 1'b0, 1000, 1'b0);
    run_frame(0, 1'b0, 1'b0, -1, 1'b0);
    check("post_abort_const", out_img[31*W+17], 100);

    // All-zero frame exercises the saturation statistic
    run_frame(3, 1'b0, 1'b0, -1, 1'b0);
`ifdef SHARPEN_SAT_STATS_EN
    check("sat_zero_frame", int'(sat_count), 3844);
`else
    check("sat_zero_frame", int'(sat_count), 0);
`endif
    check("zero_1_1", out_img[1*W+1], 0);

    // Random pixels, input gaps, backpressure and an ignored start mid-frame
    run_frame(4, 1'b1, 1'b1, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
